psum_requant_packer: RTL and testbench

- Downstream of the PE-network controller: consumes the 32-bit signed partial-sum stream and requantizes each value to int8.
- Per value: add bias, multiply by scale, arithmetic shift right, optional ReLU, saturate.
- Packs four int8 results per 32-bit word and presents them on a valid/ready stream toward the AXI write path.
- Tracks the tile's output count and pulses done after the last word is accepted.

---
 rtl/psum_requant_packer.sv | 232 +++++++++++++++++++++++
 tb/tb_psum_requant_packer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_requant_packer.sv
// Requantizes a signed partial-sum stream to int8 (bias, scale, shift, ReLU, saturate) and packs PACK bytes per word.
// Define PSUM_REQUANT_ROUND_EN for round-half-up shifting; the default build truncates toward -inf.
module psum_requant_packer #(
    parameter int PSUM_BW  = 32,
    parameter int OUT_BW   = 8,
    parameter int PACK     = 4,
    parameter int MULT_BW  = 16,
    parameter int SHIFT_BW = 6,
    parameter int CNT_BW   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [CNT_BW-1:0]      cfg_num,
    input  logic [PSUM_BW-1:0]     cfg_bias,
    input  logic [MULT_BW-1:0]     cfg_mult,
    input  logic [SHIFT_BW-1:0]    cfg_shift,
    input  logic                   cfg_relu,
    input  logic                   psum_valid,
    output logic                   psum_ready,
    input  logic [PSUM_BW-1:0]     psum_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PACK*OUT_BW-1:0] out_data,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             dbg_state
);
    localparam int S1_BW   = PSUM_BW + 1;
    localparam int S2_BW   = PSUM_BW + MULT_BW + 2;
    localparam int SX_BW   = S2_BW + 1;
    localparam int OUT_W   = PACK * OUT_BW;
    localparam int LANE_BW = (PACK > 1) ? $clog2(PACK) : 1;
    localparam logic [LANE_BW-1:0] LANE_MAX = LANE_BW'(PACK - 1);
    localparam logic signed [SX_BW-1:0] SAT_MAX = SX_BW'((1 << (OUT_BW - 1)) - 1);
    localparam logic signed [SX_BW-1:0] SAT_MIN = -SAT_MAX - SX_BW'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // The producer holds data stable while valid && !ready; ready never depends on valid.
    state_t                     state_q, state_d;
    logic [CNT_BW-1:0]          num_q, num_d;
    logic [PSUM_BW-1:0]         bias_q, bias_d;
    logic [MULT_BW-1:0]         mult_q, mult_d;
    logic [SHIFT_BW-1:0]        shift_q, shift_d;
    logic                       relu_q, relu_d;
    logic [CNT_BW-1:0]          in_cnt_q, in_cnt_d;
    logic                       s1_v_q, s1_v_d, s1_last_q, s1_last_d;
    logic signed [S1_BW-1:0]    s1_q, s1_d;
    logic                       s2_v_q, s2_v_d, s2_last_q, s2_last_d;
    logic signed [S2_BW-1:0]    s2_q, s2_d;
    logic                       s3_v_q, s3_v_d, s3_last_q, s3_last_d;
    logic [OUT_BW-1:0]          s3_q, s3_d;
    logic [LANE_BW-1:0]         lane_q, lane_d;
    logic [OUT_W-1:0]           pack_q, pack_d;
    logic                       out_valid_q, out_valid_d;
    logic [OUT_W-1:0]           out_data_q, out_data_d;
    logic                       out_last_q, out_last_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;

    logic                       adv, accept;
    logic signed [SX_BW-1:0]    rnd, shifted;
    logic [OUT_W-1:0]           word;

    assign adv        = !out_valid_q || out_ready;
    assign psum_ready = adv && (state_q == RUN) && (in_cnt_q < num_q);
    assign accept     = psum_valid && psum_ready;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

    // Stage-3 arithmetic: optional rounding, shift, ReLU, saturation.
    always_comb begin
        rnd = SX_BW'(s2_q);
`ifdef PSUM_REQUANT_ROUND_EN
        if (shift_q != '0)
            rnd = rnd + (SX_BW'(1) << (shift_q - SHIFT_BW'(1)));
`endif
        shifted = rnd >>> shift_q;
        if (relu_q && shifted[SX_BW-1])
            shifted = '0;
        if (shifted > SAT_MAX)
            s3_d = SAT_MAX[OUT_BW-1:0];
        else if (shifted < SAT_MIN)
            s3_d = SAT_MIN[OUT_BW-1:0];
        else
            s3_d = shifted[OUT_BW-1:0];
    end

    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        bias_d      = bias_q;
        mult_d      = mult_q;
        shift_d     = shift_q;
        relu_d      = relu_q;
        in_cnt_d    = in_cnt_q;
        s1_v_d      = s1_v_q;
        s1_last_d   = s1_last_q;
        s1_d        = s1_q;
        s2_v_d      = s2_v_q;
        s2_last_d   = s2_last_q;
        s2_d        = s2_q;
        s3_v_d      = s3_v_q;
        s3_last_d   = s3_last_q;
        lane_d      = lane_q;
        pack_d      = pack_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        word        = pack_q;

        if (out_valid_q && out_ready)
            out_valid_d = 1'b0;

        // All stages move together; a stalled output word freezes the whole pipe.
        if (adv) begin
            s1_v_d    = accept;
            s1_last_d = (in_cnt_q == num_q - CNT_BW'(1));
            s1_d      = S1_BW'($signed(psum_data)) + S1_BW'($signed(bias_q));
            s2_v_d    = s1_v_q;
            s2_last_d = s1_last_q;
            s2_d      = S2_BW'(s1_q) * S2_BW'($signed({1'b0, mult_q}));
            s3_v_d    = s2_v_q;
            s3_last_d = s2_last_q;
            if (s3_v_q) begin
                word[int'(lane_q)*OUT_BW +: OUT_BW] = s3_q;
                if (lane_q == LANE_MAX || s3_last_q) begin
                    out_data_d  = word;
                    out_valid_d = 1'b1;
                    out_last_d  = s3_last_q;
                    pack_d      = '0;
                    lane_d      = '0;
                end else begin
                    pack_d = word;
                    lane_d = lane_q + LANE_BW'(1);
                end
            end
        end

        if (accept)
            in_cnt_d = in_cnt_q + CNT_BW'(1);

        case (state_q)
            IDLE: begin
                if (start) begin
                    num_d    = cfg_num;
                    bias_d   = cfg_bias;
                    mult_d   = cfg_mult;
                    shift_d  = cfg_shift;
                    relu_d   = cfg_relu;
                    in_cnt_d = '0;
                    lane_d   = '0;
                    pack_d   = '0;
                    state_d  = (cfg_num == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept && (in_cnt_q + CNT_BW'(1) == num_q))
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (out_valid_q && out_ready && out_last_q)
                    state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            num_q       <= '0;
            bias_q      <= '0;
            mult_q      <= '0;
            shift_q     <= '0;
            relu_q      <= 1'b0;
            in_cnt_q    <= '0;
            s1_v_q      <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_q        <= '0;
            s2_v_q      <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_q        <= '0;
            s3_v_q      <= 1'b0;
            s3_last_q   <= 1'b0;
            s3_q        <= '0;
            lane_q      <= '0;
            pack_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            bias_q      <= bias_d;
            mult_q      <= mult_d;
            shift_q     <= shift_d;
            relu_q      <= relu_d;
            in_cnt_q    <= in_cnt_d;
            s1_v_q      <= s1_v_d;
            s1_last_q   <= s1_last_d;
            s1_q        <= s1_d;
            s2_v_q      <= s2_v_d;
            s2_last_q   <= s2_last_d;
            s2_q        <= s2_d;
            s3_v_q      <= s3_v_d;
            s3_last_q   <= s3_last_d;
            if (adv)
                s3_q    <= s3_d;
            lane_q      <= lane_d;
            pack_q      <= pack_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end
endmodule

// File: tb/tb_psum_requant_packer.sv
// Directed bench for psum_requant_packer: expected words queued by the driver, checked by a forked monitor.
module tb_psum_requant_packer;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] cfg_num;
    logic [31:0] cfg_bias;
    logic [15:0] cfg_mult;
    logic [5:0]  cfg_shift;
    logic        cfg_relu;
    logic        psum_valid;
    logic        psum_ready;
    logic [31:0] psum_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;
    logic [1:0]  dbg_state;

    logic [32:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    logic feed_done;

    psum_requant_packer dut (
        .clk(clk), .reset(reset), .start(start), .cfg_num(cfg_num),
        .cfg_bias(cfg_bias), .cfg_mult(cfg_mult), .cfg_shift(cfg_shift),
        .cfg_relu(cfg_relu), .psum_valid(psum_valid), .psum_ready(psum_ready),
        .psum_data(psum_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy), .done(done),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] w, input logic last);
        exp_q.push_back({last, w});
    endtask

    task automatic do_start(input logic [15:0] num, input logic [31:0] bias,
                            input logic [15:0] mult, input logic [5:0] shift, input logic relu);
        cfg_num = num; cfg_bias = bias; cfg_mult = mult; cfg_shift = shift; cfg_relu = relu;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_psum(input logic [31:0] d);
        int t;
        t = 0;
        psum_valid = 1'b1;
        psum_data  = d;
        forever begin
            @(negedge clk);
            if (psum_ready) break;
            t++;
            if (t > 200) begin
                check("psum_accept_timeout", 32'd1, 32'd0);
                break;
            end
        end
        tick();
        psum_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int t;
        logic seen;
        t = 0;
        seen = 1'b0;
        while (t < budget && !seen) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            t++;
        end
        check("done_seen", {31'b0, seen}, 32'd1);
        @(negedge clk);
        check("done_one_cycle", {31'b0, done}, 32'd0);
        tick();
    endtask

    task automatic monitor();
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", out_data, 32'hxxxx_xxxx);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e[31:0]);
                    check("out_last", {31'b0, out_last}, {31'b0, e[32]});
                end
            end
        end
    endtask

    task automatic feeder12();
        for (int i = 0; i < 12; i++) send_psum(i);
        feed_done = 1'b1;
    endtask

    initial begin
        logic [31:0] cap;
        logic pr_bad, stab_bad, saw_ov;
        int done_n, done_at, t;

        reset = 1'b1; start = 1'b0; cfg_num = '0; cfg_bias = '0; cfg_mult = '0;
        cfg_shift = '0; cfg_relu = 1'b0; psum_valid = 1'b0; psum_data = '0;
        out_ready = 1'b1; feed_done = 1'b0;
        fork monitor(); join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_last", {31'b0, out_last}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_psum_ready", {31'b0, psum_ready}, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Basic packing and done timing
        push_exp(32'h807FFF01, 1'b1);
        do_start(16'd4, 32'd0, 16'd1, 6'd0, 1'b0);
        @(negedge clk);
        check("busy_run", {31'b0, busy}, 32'd1);
        tick();
        send_psum(32'd1); send_psum(-32'sd1); send_psum(32'd127); send_psum(-32'sd128);
        t = 0;
        do begin @(negedge clk); t++; end while (!out_valid && t < 20);
        check("word1_valid", {31'b0, out_valid}, 32'd1);
        @(negedge clk);
        check("done_after_hs", {31'b0, done}, 32'd1);
        @(negedge clk);
        check("done_pulse_end", {31'b0, done}, 32'd0);
        check("idle_not_busy", {31'b0, busy}, 32'd0);
        tick();

        // Bias, scale and shift
`ifdef PSUM_REQUANT_ROUND_EN
        push_exp(32'h0000F117, 1'b1);
`else
        push_exp(32'h0000F116, 1'b1);
`endif
        do_start(16'd2, 32'd10, 16'd3, 6'd1, 1'b0);
        send_psum(32'd5); send_psum(-32'sd20);
        wait_done(50);

        // Saturation without and with ReLU
        push_exp(32'h0000807F, 1'b1);
        do_start(16'd2, 32'd0, 16'd1, 6'd0, 1'b0);
        send_psum(32'd100000); send_psum(-32'sd100000);
        wait_done(50);
        push_exp(32'h0000007F, 1'b1);
        do_start(16'd2, 32'd0, 16'd1, 6'd0, 1'b1);
        send_psum(32'd100000); send_psum(-32'sd100000);
        wait_done(50);

        // Shift behaviour on positive, negative and saturating values
`ifdef PSUM_REQUANT_ROUND_EN
        push_exp(32'hFF7FFD05, 1'b1);
`else
        push_exp(32'hFF7FFD04, 1'b1);
`endif
        do_start(16'd4, 32'd0, 16'd1000, 6'd10, 1'b0);
        send_psum(32'd5); send_psum(-32'sd3); send_psum(32'd1000000); send_psum(-32'sd1);
        wait_done(50);

        // Extreme operands: max psum + max bias, max mult, max shift, single-element tile
`ifdef PSUM_REQUANT_ROUND_EN
        push_exp(32'h00000002, 1'b1);
`else
        push_exp(32'h00000001, 1'b1);
`endif
        do_start(16'd1, 32'h7FFFFFFF, 16'hFFFF, 6'd47, 1'b0);
        send_psum(32'h7FFFFFFF);
        wait_done(50);

        // Backpressure, with a start pulse that must be ignored mid-tile
        push_exp(32'h03020100, 1'b0);
        push_exp(32'h07060504, 1'b0);
        push_exp(32'h0B0A0908, 1'b1);
        out_ready = 1'b0;
        do_start(16'd12, 32'd0, 16'd1, 6'd0, 1'b0);
        feed_done = 1'b0;
        fork feeder12(); join_none
        do_start(16'd1, 32'd100, 16'd7, 6'd2, 1'b1);
        t = 0;
        do begin @(negedge clk); t++; end while (!out_valid && t < 100);
        check("bp_word_valid", {31'b0, out_valid}, 32'd1);
        cap = out_data;
        pr_bad = 1'b0; stab_bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (psum_ready) pr_bad = 1'b1;
            if (out_data !== cap || !out_valid) stab_bad = 1'b1;
        end
        check("bp_psum_ready_low", {31'b0, pr_bad}, 32'd0);
        check("bp_data_stable", {31'b0, stab_bad}, 32'd0);
        check("bp_held_word", cap, 32'h03020100);
        tick();
        out_ready = 1'b1;
        wait_done(300);
        check("bp_feeder_done", {31'b0, feed_done}, 32'd1);

        // Empty tile
        do_start(16'd0, 32'd0, 16'd1, 6'd0, 1'b0);
        done_n = 0; done_at = -1; saw_ov = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) begin
                done_n++;
                if (done_at < 0) done_at = i;
            end
            if (out_valid) saw_ov = 1'b1;
        end
        check("empty_done_count", done_n, 32'd1);
        check("empty_done_early", {31'b0, (done_at >= 0 && done_at <= 1)}, 32'd1);
        check("empty_no_out_valid", {31'b0, saw_ov}, 32'd0);
        tick();

        // Reset mid-tile, then a clean tile
        do_start(16'd4, 32'd0, 16'd1, 6'd0, 1'b0);
        send_psum(32'd7); send_psum(32'd8);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_out_data", out_data, 32'd0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_psum_ready", {31'b0, psum_ready}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        push_exp(32'h23190F05, 1'b1);
        do_start(16'd4, -32'sd5, 16'd2, 6'd1, 1'b0);
        send_psum(32'd10); send_psum(32'd20); send_psum(32'd30); send_psum(32'd40);
        wait_done(50);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
